// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int   BEATS   = 4;
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the multicycle core, the arbiter and the byte-wide memory.
// Handshake: a port holds its req level until the cycle its done pulses; done marks rdata valid.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              if_req;
   logic [31:0]       if_adr;
   logic              if_done;
   logic [31:0]       if_rdata;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_adr;
   logic [31:0]       d_wdata;
   logic              d_done;
   logic [31:0]       d_rdata;
   logic [ADDR_W-1:0] m_adr;
   logic              m_we;
   logic [7:0]        m_wdata;
   logic [7:0]        m_rdata;

   modport master (
      output if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
      input  if_done, if_rdata, d_done, d_rdata, m_adr, m_we, m_wdata
   );

   modport slave (
      input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, m_rdata,
      output if_done, if_rdata, d_done, d_rdata, m_adr, m_we, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Two-requester grant logic. MEM_ARB_RR_EN selects round-robin; otherwise D wins every tie.
module arb2_rr
   import mips_mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_if_i,
   input  logic req_d_i,
   input  logic take_i,
   output logic gnt_valid_o,
   output logic gnt_id_o
);

   assign gnt_valid_o = req_if_i | req_d_i;

`ifdef MEM_ARB_RR_EN
   // prio_q names the port that wins the next tie
   logic prio_q, prio_d;

   always_comb begin
      gnt_id_o = req_d_i ? PORT_D : PORT_IF;
      if (req_if_i && req_d_i) gnt_id_o = prio_q;
      prio_d = prio_q;
      if (take_i && gnt_valid_o) prio_d = ~gnt_id_o;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) prio_q <= PORT_IF;
      else        prio_q <= prio_d;
   end
`else
   logic unused_arb;
   assign unused_arb = ^{clk, rst_n, take_i};
   assign gnt_id_o   = req_d_i ? PORT_D : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises 32-bit IF/D accesses into four little-endian byte beats on a shared memory.
// Tie policy set by MEM_ARB_RR_EN (round-robin when defined, D-priority otherwise).
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_port_arbiter_if.slave   bus,
   output state_t              dbg_state_o
);

   state_t            state_q;
   logic [1:0]        beat_q;
   logic              port_q;
   logic [ADDR_W-1:0] m_adr_q;
   logic              m_we_q;
   logic [7:0]        m_wdata_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf_q, rbuf_d;
   logic [31:0]       if_rdata_q, d_rdata_q;
   logic              if_done_q, d_done_q;
   logic              gnt_valid, gnt_id;
   logic [31:0]       sel_wdata;
   logic              unused_adr_hi;

   arb2_rr u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_if_i    (bus.if_req),
      .req_d_i     (bus.d_req),
      .take_i      (state_q == IDLE),
      .gnt_valid_o (gnt_valid),
      .gnt_id_o    (gnt_id)
   );

   // Incoming bytes enter at the top so beat 0 ends up in bits [7:0].
   assign rbuf_d        = {bus.m_rdata, rbuf_q[31:8]};
   assign sel_wdata     = (gnt_id == PORT_D && bus.d_we) ? bus.d_wdata : 32'h0;
   assign unused_adr_hi = ^{bus.if_adr[31:ADDR_W], bus.d_adr[31:ADDR_W]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_q     <= 2'd0;
         port_q     <= PORT_IF;
         m_adr_q    <= '0;
         m_we_q     <= 1'b0;
         m_wdata_q  <= 8'h0;
         wdata_q    <= 32'h0;
         rbuf_q     <= 32'h0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  port_q    <= gnt_id;
                  m_adr_q   <= (gnt_id == PORT_D) ? bus.d_adr[ADDR_W-1:0] : bus.if_adr[ADDR_W-1:0];
                  m_we_q    <= (gnt_id == PORT_D) & bus.d_we;
                  wdata_q   <= sel_wdata;
                  m_wdata_q <= sel_wdata[7:0];
                  beat_q    <= 2'd0;
                  state_q   <= XFER;
               end
            end
            XFER: begin
               rbuf_q    <= rbuf_d;
               wdata_q   <= {8'h0, wdata_q[31:8]};
               m_wdata_q <= wdata_q[15:8];
               beat_q    <= beat_q + 2'd1;
               if (beat_q == 2'(BEATS - 1)) begin
                  m_we_q  <= 1'b0;
                  state_q <= DONE;
                  if (port_q == PORT_IF) begin
                     if_rdata_q <= rbuf_d;
                     if_done_q  <= 1'b1;
                  end else begin
                     if (!m_we_q) d_rdata_q <= rbuf_d;
                     d_done_q <= 1'b1;
                  end
               end else begin
                  m_adr_q <= m_adr_q + ADDR_W'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.if_done  = if_done_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_done   = d_done_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.m_adr    = m_adr_q;
   // A reset arriving mid-beat must suppress that beat's write at the coming edge.
   assign bus.m_we     = m_we_q & rst_n;
   assign bus.m_wdata  = m_wdata_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, load scoreboard, arbitration and reset corner cases.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16)) bus();
  state_t dbg_state;

  mem_port_arbiter #(.ADDR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // byte memory with a bench preload port
  logic [7:0]  mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_adr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  assign bus.m_rdata = mem[bus.m_adr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_adr] <= pl_data;
    else if (bus.m_we) mem[bus.m_adr] <= bus.m_wdata;
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_adr = a; pl_data = d;
    tick;
    pl_we = 1'b0;
  endtask

  // one access from IDLE, checking every beat, the done pulse and rdata
  task automatic run_access(input string name, input logic is_d, input logic we,
                            input logic [31:0] adr, input logic [31:0] wdata, input logic [31:0] exp);
    logic [15:0] ea;
    logic [31:0] got, want;
    if (!we) exp_q.push_back(exp);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_adr = adr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_adr = adr;
    end
    for (int b = 0; b < 4; b++) begin
      tick;
      ea = adr[15:0] + 16'(b);
      check($sformatf("%s beat%0d state", name, b), 32'(dbg_state), 32'(XFER));
      check($sformatf("%s beat%0d m_adr", name, b), 32'(bus.m_adr), 32'(ea));
      check($sformatf("%s beat%0d m_we", name, b), 32'(bus.m_we), 32'(we));
      if (we) check($sformatf("%s beat%0d m_wdata", name, b), 32'(bus.m_wdata), 32'(wdata[8*b +: 8]));
    end
    tick;
    check({name, " done"}, 32'(is_d ? bus.d_done : bus.if_done), 32'd1);
    check({name, " other done"}, 32'(is_d ? bus.if_done : bus.d_done), 32'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    if (!we) begin
      got  = is_d ? bus.d_rdata : bus.if_rdata;
      want = exp_q.pop_front();
      check({name, " rdata"}, got, want);
    end
    tick;
    check({name, " done clears"}, 32'(bus.if_done | bus.d_done), 32'd0);
    check({name, " back idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  logic        exp_gnt [4];
  logic        got_any, got_port;
  logic [31:0] rw;
  logic [15:0] ra;
  int          ndone;

  initial begin
    bus.if_req = 1'b0; bus.if_adr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 32'h0; bus.d_wdata = 32'h0;

    // reset state
    rst_n = 1'b0;
    tick; tick;
    check("rst state", 32'(dbg_state), 32'(IDLE));
    check("rst if_done", 32'(bus.if_done), 32'd0);
    check("rst d_done", 32'(bus.d_done), 32'd0);
    check("rst if_rdata", bus.if_rdata, 32'h0);
    check("rst d_rdata", bus.d_rdata, 32'h0);
    check("rst m_adr", 32'(bus.m_adr), 32'h0);
    check("rst m_we", 32'(bus.m_we), 32'd0);
    check("rst m_wdata", 32'(bus.m_wdata), 32'h0);
    rst_n = 1'b1;

    poke(16'h0000, 8'h20); poke(16'h0001, 8'h50);
    poke(16'h0002, 8'h00); poke(16'h0003, 8'h00);
    poke(16'h00CC, 8'h5A);

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_5020};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_00C8, 32'h2401_0014, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_00C8, 32'h0, 32'h2401_0014};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_00C8, 32'h0, 32'h2401_0014};
    vecs[4] = '{1'b1, 1'b1, 32'hABCD_FFFE, 32'hAABB_CCDD, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 32'hAABB_CCDD};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_AABB};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_00C9, 32'h0, 32'h5A24_0100};
    for (int i = 0; i < 8; i++)
      run_access($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].exp);

    check("mem C8", 32'(mem[16'h00C8]), 32'h14);
    check("mem C9", 32'(mem[16'h00C9]), 32'h00);
    check("mem CA", 32'(mem[16'h00CA]), 32'h01);
    check("mem CB", 32'(mem[16'h00CB]), 32'h24);
    check("mem FFFE", 32'(mem[16'hFFFE]), 32'hDD);
    check("mem FFFF", 32'(mem[16'hFFFF]), 32'hCC);
    check("mem 0000", 32'(mem[16'h0000]), 32'hBB);
    check("mem 0001", 32'(mem[16'h0001]), 32'hAA);

    // random store / load-back pairs
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(16'h1000, 16'h1FFF));
      rw = $urandom;
      run_access($sformatf("rnd%0d st", i), 1'b1, 1'b1, {16'h0, ra}, rw, 32'h0);
      run_access($sformatf("rnd%0d ld", i), 1'b1, 1'b0, {16'h0, ra}, 32'h0, rw);
    end

    // arbitration with both requests held, from a fresh reset
    rst_n = 1'b0; tick; rst_n = 1'b1;
`ifdef MEM_ARB_RR_EN
    exp_gnt[0] = PORT_IF; exp_gnt[1] = PORT_D; exp_gnt[2] = PORT_IF; exp_gnt[3] = PORT_D;
`else
    exp_gnt[0] = PORT_D; exp_gnt[1] = PORT_D; exp_gnt[2] = PORT_D; exp_gnt[3] = PORT_IF;
`endif
    bus.if_req = 1'b1; bus.if_adr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 32'hC8;
    for (int k = 0; k < 4; k++) begin
      got_any = 1'b0;
      got_port = PORT_IF;
      for (int c = 0; c < 12 && !got_any; c++) begin
        tick;
        if (bus.if_done || bus.d_done) begin
          got_any = 1'b1;
          got_port = bus.d_done ? PORT_D : PORT_IF;
          check($sformatf("arb%0d single done", k), 32'(bus.if_done & bus.d_done), 32'd0);
        end
      end
      check($sformatf("arb%0d seen", k), 32'(got_any), 32'd1);
      if (!got_any) break;
      check($sformatf("arb%0d port", k), 32'(got_port), 32'(exp_gnt[k]));
`ifndef MEM_ARB_RR_EN
      if (k == 2) bus.d_req = 1'b0;
`endif
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick; tick;

    // reset during beat 2 of a store: only bytes 0 and 1 land
    poke(16'h0040, 8'h00); poke(16'h0041, 8'h00);
    poke(16'h0042, 8'h00); poke(16'h0043, 8'h00);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_adr = 32'h40; bus.d_wdata = 32'h1122_3344;
    tick; tick; tick;
    check("rstmid beat2 adr", 32'(bus.m_adr), 32'h42);
    rst_n = 1'b0;
    #1;
    check("rstmid m_we gated", 32'(bus.m_we), 32'd0);
    tick;
    check("rstmid state", 32'(dbg_state), 32'(IDLE));
    check("rstmid m_we", 32'(bus.m_we), 32'd0);
    check("rstmid d_done", 32'(bus.d_done), 32'd0);
    bus.d_req = 1'b0;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (bus.d_done) ndone++;
    end
    check("rstmid no done", 32'(ndone), 32'd0);
    check("rstmid mem40", 32'(mem[16'h0040]), 32'h44);
    check("rstmid mem41", 32'(mem[16'h0041]), 32'h33);
    check("rstmid mem42", 32'(mem[16'h0042]), 32'h00);
    check("rstmid mem43", 32'(mem[16'h0043]), 32'h00);

    // fetch request withdrawn during beat 1 still completes
    exp_q.push_back(32'h0000_AABB);
    bus.if_req = 1'b1; bus.if_adr = 32'h0;
    tick; tick;
    bus.if_req = 1'b0;
    tick; tick; tick;
    check("ifdrop done", 32'(bus.if_done), 32'd1);
    check("ifdrop rdata", bus.if_rdata, exp_q.pop_front());
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (bus.if_done || bus.d_done) ndone++;
    end
    check("ifdrop single pulse", 32'(ndone), 32'd0);
    check("ifdrop rdata held", bus.if_rdata, 32'h0000_AABB);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
